ber_frame_monitor: RTL and testbench
====================================

BER_FRAME_MONITOR -- requirements
Module: ber_frame_monitor

Interface
REQ-001 SHALL have parameter FRAME_SYM, default 96, the number of symbols per frame.
REQ-002 SHALL have parameter UP_FRAMES, default 4, the consecutive error-free QPSK frames needed to request QAM.
REQ-003 SHALL have parameter DN_ERR, default 8, the QAM frame bit-error count above which QPSK is requested.
REQ-004 SHALL have port CLK_I, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST_I, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port DAT_I, input, 4 bits: received demodulated symbol from the OFDM RX output.
REQ-007 SHALL have port REF_I, input, 4 bits: transmitted reference symbol, time-aligned with DAT_I.
REQ-008 SHALL have ports CYC_I, STB_I and WE_I, inputs, 1 bit each: bus qualifiers of the RX output stream.
REQ-009 SHALL have ports QAM and QPSK, inputs, 1 bit each: current modulation mode flags.
REQ-010 SHALL have port ACK_O, output, 1 bit: registered acknowledge of each accepted beat.
REQ-011 SHALL have port ERR_CNT, output, 10 bits: bit errors in the last completed frame.
REQ-012 SHALL have port CORR_CNT, output, 10 bits: correct bits in the last completed frame.
REQ-013 SHALL have port FRM_DONE, output, 1 bit: one-cycle pulse when ERR_CNT and CORR_CNT update.
REQ-014 SHALL have port FRM_ABORT, output, 1 bit: one-cycle pulse when a frame is abandoned.
REQ-015 SHALL have port FRM_CNT, output, 16 bits: count of completed frames.
REQ-016 SHALL have port HIGH_REQ, output, 1 bit: recommends QAM (high-SNR mode).
REQ-017 SHALL have port LOW_REQ, output, 1 bit: recommends QPSK (low-SNR mode).

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE.
REQ-019 SHALL move IDLE->RUN on the cycle CYC_I=1 and (QAM or QPSK)=1, latching mode; QAM has priority if both are high; neither high keeps IDLE.
REQ-020 SHALL accept a beat when the state is RUN and CYC_I&STB_I&WE_I=1; there is no back-pressure.
REQ-021 SHALL assert ACK_O for exactly one cycle, the cycle after each accepted beat.
REQ-022 SHALL compute per-beat errors as popcount(DAT_I^REF_I) over all 4 bits in QAM mode and over bits [1:0] only in QPSK mode.
REQ-023 SHALL add per beat 4 minus errors (QAM) or 2 minus errors (QPSK) to the correct-bit accumulator.
REQ-024 SHALL hold accumulators 10 bits wide; the maximum value is 384 (96x4), so no saturation is needed.
REQ-025 SHALL go RUN->DONE on the accepted beat that makes the symbol count equal FRAME_SYM.
REQ-026 SHALL, in DONE, publish the accumulators to ERR_CNT/CORR_CNT, pulse FRM_DONE, increment FRM_CNT (wrapping at 65535->0), clear accumulators and go to IDLE; this takes one cycle.
REQ-027 SHALL, in RUN, treat CYC_I=0 before FRAME_SYM beats as an abort: pulse FRM_ABORT, clear accumulators, go to IDLE, and leave ERR_CNT/CORR_CNT/FRM_CNT unchanged.
REQ-028 SHALL ignore mode-flag changes during RUN; the mode is the value latched at frame start.
REQ-029 SHALL apply the mode decision in DONE:
  - QPSK frame with ERR_CNT=0: increment the clean-frame counter.
  - QPSK frame with ERR_CNT>0: clear the clean-frame counter.
  - When the clean-frame counter reaches UP_FRAMES: set HIGH_REQ=1, LOW_REQ=0, clear the counter.
REQ-030 SHALL, on a QAM frame with ERR_CNT>DN_ERR, set LOW_REQ=1 and HIGH_REQ=0 in the same DONE cycle and clear the clean-frame counter.
REQ-031 SHALL always keep HIGH_REQ and LOW_REQ mutually exclusive; they hold their value until the next decision.
REQ-032 SHALL make updated ERR_CNT/CORR_CNT/HIGH_REQ/LOW_REQ visible in the same cycle FRM_DONE=1.

Reset
REQ-033 SHALL, while RST_I=0 at a clock edge, set the state to IDLE and clear ACK_O, ERR_CNT, CORR_CNT, FRM_DONE, FRM_ABORT, FRM_CNT, HIGH_REQ, the accumulators and the clean-frame counter.
REQ-034 SHALL, while RST_I=0 at a clock edge, set LOW_REQ=1 (robust mode by default).
REQ-035 SHALL abandon any frame in progress when reset is applied mid-frame, with no FRM_DONE or FRM_ABORT pulse.

Verification
REQ-036 SHALL cover: QAM, 96 beats with DAT_I=REF_I -> FRM_DONE once, ERR_CNT=0, CORR_CNT=384, FRM_CNT=1, 96 ACK_O pulses.
REQ-037 SHALL cover: QPSK, 96 beats with DAT_I=4'b1101 and REF_I=4'b0001 -> ERR_CNT=0, CORR_CNT=192 (upper bits ignored); then DAT_I=4'b0010 and REF_I=4'b0001 on all beats -> ERR_CNT=192, CORR_CNT=0.
REQ-038 SHALL cover: QPSK, 4 consecutive error-free frames -> HIGH_REQ=1 and LOW_REQ=0 at the 4th FRM_DONE; with one bit error in frame 3, HIGH_REQ is reached only at frame 7.
REQ-039 SHALL cover: QAM frame with 9 bit errors -> LOW_REQ=1; with exactly 8 bit errors -> the request is unchanged.
REQ-040 SHALL cover: CYC_I dropped after 50 beats -> FRM_ABORT pulse, ERR_CNT/FRM_CNT unchanged, and the next full frame counts from 0.
REQ-041 SHALL cover: RST_I=0 at beat 30, then released and a full frame sent -> no pulse during reset, all outputs at reset values, and a correct FRM_DONE afterwards with FRM_CNT=1.

Source files
------------

// File: rtl/ber_frame_monitor.sv
// Frame-based bit-error monitor for the OFDM RX output stream. Counts bit errors per frame
// against a time-aligned reference and recommends QAM/QPSK from the per-frame results.
module ber_frame_monitor #(
  parameter int unsigned FRAME_SYM = 96,
  parameter int unsigned UP_FRAMES = 4,
  parameter int unsigned DN_ERR    = 8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:0]  DAT_I,
  input  logic [3:0]  REF_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        QAM,
  input  logic        QPSK,
  output logic        ACK_O,
  output logic [9:0]  ERR_CNT,
  output logic [9:0]  CORR_CNT,
  output logic        FRM_DONE,
  output logic        FRM_ABORT,
  output logic [15:0] FRM_CNT,
  output logic        HIGH_REQ,
  output logic        LOW_REQ
);

  localparam int unsigned SymW   = $clog2(FRAME_SYM + 1);
  localparam int unsigned CleanW = $clog2(UP_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic              r_mode_qam;
  logic [SymW-1:0]   r_sym_cnt;
  logic [9:0]        r_err_acc;
  logic [9:0]        r_corr_acc;
  logic [CleanW-1:0] r_clean_cnt;

  logic              w_beat;
  logic [3:0]        w_diff;
  logic [2:0]        w_beat_err;
  logic [2:0]        w_beat_corr;
  logic              w_last_beat;
  logic [CleanW-1:0] w_clean_nxt;

  always_comb begin
    w_beat      = (r_state == StRun) & CYC_I & STB_I & WE_I;
    // QPSK symbols only carry information in the two low bits
    w_diff      = (DAT_I ^ REF_I) & (r_mode_qam ? 4'hF : 4'h3);
    w_beat_err  = 3'(w_diff[0]) + 3'(w_diff[1]) + 3'(w_diff[2]) + 3'(w_diff[3]);
    w_beat_corr = (r_mode_qam ? 3'd4 : 3'd2) - w_beat_err;
    w_last_beat = (r_sym_cnt == SymW'(FRAME_SYM - 1));
    w_clean_nxt = r_clean_cnt + CleanW'(1);
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_state     <= StIdle;
      r_mode_qam  <= 1'b0;
      r_sym_cnt   <= '0;
      r_err_acc   <= '0;
      r_corr_acc  <= '0;
      r_clean_cnt <= '0;
      ACK_O       <= 1'b0;
      ERR_CNT     <= '0;
      CORR_CNT    <= '0;
      FRM_DONE    <= 1'b0;
      FRM_ABORT   <= 1'b0;
      FRM_CNT     <= '0;
      HIGH_REQ    <= 1'b0;
      LOW_REQ     <= 1'b1;
    end else begin
      ACK_O     <= w_beat;
      FRM_DONE  <= 1'b0;
      FRM_ABORT <= 1'b0;
      case (r_state)
        StIdle: begin
          if (CYC_I && (QAM || QPSK)) begin
            r_state    <= StRun;
            r_mode_qam <= QAM;
            r_sym_cnt  <= '0;
          end
        end
        StRun: begin
          if (!CYC_I) begin
            FRM_ABORT  <= 1'b1;
            r_err_acc  <= '0;
            r_corr_acc <= '0;
            r_sym_cnt  <= '0;
            r_state    <= StIdle;
          end else if (w_beat) begin
            r_err_acc  <= r_err_acc + {7'd0, w_beat_err};
            r_corr_acc <= r_corr_acc + {7'd0, w_beat_corr};
            r_sym_cnt  <= r_sym_cnt + SymW'(1);
            if (w_last_beat) r_state <= StDone;
          end
        end
        StDone: begin
          ERR_CNT    <= r_err_acc;
          CORR_CNT   <= r_corr_acc;
          FRM_DONE   <= 1'b1;
          FRM_CNT    <= FRM_CNT + 16'd1;
          r_err_acc  <= '0;
          r_corr_acc <= '0;
          r_sym_cnt  <= '0;
          r_state    <= StIdle;
          if (!r_mode_qam) begin
            if (r_err_acc == '0) begin
              if (w_clean_nxt == CleanW'(UP_FRAMES)) begin
                HIGH_REQ    <= 1'b1;
                LOW_REQ     <= 1'b0;
                r_clean_cnt <= '0;
              end else begin
                r_clean_cnt <= w_clean_nxt;
              end
            end else begin
              r_clean_cnt <= '0;
            end
          end else if (r_err_acc > 10'(DN_ERR)) begin
            LOW_REQ     <= 1'b1;
            HIGH_REQ    <= 1'b0;
            r_clean_cnt <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_frame_monitor.sv
// Bench for ber_frame_monitor: directed mode-decision scenarios plus randomized frames,
// checked against a frame-level reference model built from the symbol arrays.
module tb_ber_frame_monitor;

  localparam int FS = 96;
  localparam int UP = 4;
  localparam int DN = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dat, refs;
  logic        cyc, stb, we, qam, qpsk;
  logic        ack, frm_done, frm_abort, high_req, low_req;
  logic [9:0]  err_cnt, corr_cnt;
  logic [15:0] frm_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] tb_dat [FS];
  logic [3:0] tb_ref [FS];

  // Reference model state
  int m_err, m_corr, m_frm, m_clean;
  bit m_high, m_low;

  always #5 clk = ~clk;

  ber_frame_monitor #(.FRAME_SYM(FS), .UP_FRAMES(UP), .DN_ERR(DN)) dut (
    .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat), .REF_I(refs),
    .CYC_I(cyc), .STB_I(stb), .WE_I(we), .QAM(qam), .QPSK(qpsk),
    .ACK_O(ack), .ERR_CNT(err_cnt), .CORR_CNT(corr_cnt), .FRM_DONE(frm_done),
    .FRM_ABORT(frm_abort), .FRM_CNT(frm_cnt), .HIGH_REQ(high_req), .LOW_REQ(low_req)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    m_err = 0; m_corr = 0; m_frm = 0; m_clean = 0; m_high = 0; m_low = 1;
  endtask

  // Fill the symbol arrays; nerr < 0 gives fully random data, otherwise exactly nerr
  // flipped information bits (QPSK upper bits are randomized since they must not count).
  task automatic build_frame(input bit q, input int nerr);
    logic [3:0] fl [FS];
    int placed, b, bt;
    for (int i = 0; i < FS; i++) begin
      tb_ref[i] = 4'($urandom);
      tb_dat[i] = tb_ref[i];
      if (!q) tb_dat[i][3:2] = 2'($urandom);
      if (nerr < 0) tb_dat[i] = 4'($urandom);
      fl[i] = 4'h0;
    end
    placed = 0;
    while (placed < nerr) begin
      b  = $urandom_range(0, FS - 1);
      bt = q ? $urandom_range(0, 3) : $urandom_range(0, 1);
      if (!fl[b][bt]) begin
        fl[b][bt]     = 1'b1;
        tb_dat[b][bt] = ~tb_dat[b][bt];
        placed++;
      end
    end
  endtask

  task automatic model_frame(input bit q);
    logic [3:0] mask;
    int e;
    mask = q ? 4'hF : 4'h3;
    e = 0;
    for (int i = 0; i < FS; i++) e += $countones((tb_dat[i] ^ tb_ref[i]) & mask);
    m_err  = e;
    m_corr = FS * (q ? 4 : 2) - e;
    m_frm  = (m_frm + 1) % 65536;
    if (!q) begin
      if (e == 0) begin
        m_clean++;
        if (m_clean == UP) begin m_high = 1; m_low = 0; m_clean = 0; end
      end else begin
        m_clean = 0;
      end
    end else if (e > DN) begin
      m_low = 1; m_high = 0; m_clean = 0;
    end
  endtask

  // Send nbeats beats of tb_dat/tb_ref with random idle gaps, then drop CYC_I.
  task automatic drive_frame(input bit q, input int nbeats);
    int acks, bad, dones, aborts, i, old_err, old_frm;
    bit gap;
    acks = 0; bad = 0; dones = 0; aborts = 0; i = 0;
    old_err = int'(err_cnt); old_frm = int'(frm_cnt);
    qam = q; qpsk = q ? 1'($urandom) : 1'b1;
    cyc = 1; stb = 0; we = 1;
    tick;
    if (ack !== 1'b0) bad++;
    while (i < nbeats) begin
      qam  = 1'($urandom);
      qpsk = 1'($urandom);
      gap  = ($urandom_range(0, 4) == 0);
      if (gap) begin
        stb = 1'($urandom); we = ~stb;
        dat = 4'($urandom); refs = 4'($urandom);
      end else begin
        stb = 1; we = 1; dat = tb_dat[i]; refs = tb_ref[i];
      end
      tick;
      if (ack !== !gap) bad++;
      acks += int'(ack); dones += int'(frm_done); aborts += int'(frm_abort);
      if (!gap) i++;
    end
    cyc = 0; stb = 0; qam = 0; qpsk = 0;
    tick;
    if (ack !== 1'b0) bad++;
    dones += int'(frm_done); aborts += int'(frm_abort);
    check("ack_count", acks, nbeats);
    check("ack_timing_errors", bad, 0);
    if (nbeats == FS) begin
      model_frame(q);
      check("done_pulses", dones, 1);
      check("done_now", frm_done, 1);
      check("abort_pulses", aborts, 0);
      check("err_cnt", err_cnt, m_err);
      check("corr_cnt", corr_cnt, m_corr);
      check("frm_cnt", frm_cnt, m_frm);
      check("high_req", high_req, m_high);
      check("low_req", low_req, m_low);
    end else begin
      check("abort_pulses", aborts, 1);
      check("abort_now", frm_abort, 1);
      check("abort_no_done", dones, 0);
      check("abort_err_kept", err_cnt, old_err);
      check("abort_frm_kept", frm_cnt, old_frm);
    end
    tick;
    check("pulse_one_cycle", {frm_done, frm_abort}, 0);
  endtask

  initial begin
    int pulses, acks, r;
    bit q;
    rst_n = 0; dat = 0; refs = 0; cyc = 0; stb = 0; we = 0; qam = 0; qpsk = 0;
    model_reset();
    repeat (3) tick;
    check("rst_ack", ack, 0);
    check("rst_err", err_cnt, 0);
    check("rst_corr", corr_cnt, 0);
    check("rst_pulses", {frm_done, frm_abort}, 0);
    check("rst_frm_cnt", frm_cnt, 0);
    check("rst_high", high_req, 0);
    check("rst_low", low_req, 1);
    rst_n = 1;
    tick;

    // No mode flag: must stay idle and accept nothing
    cyc = 1; stb = 1; we = 1; acks = 0;
    repeat (3) begin tick; acks += int'(ack); end
    check("idle_no_mode_ack", acks, 0);
    cyc = 0; stb = 0;
    tick;

    // Clean QAM frame
    build_frame(1, 0);
    drive_frame(1, FS);
    check("qam_clean_corr", corr_cnt, 384);

    // QPSK ignores upper bits, then all low bits wrong
    for (int i = 0; i < FS; i++) begin tb_dat[i] = 4'b1101; tb_ref[i] = 4'b0001; end
    drive_frame(0, FS);
    check("qpsk_upper_ignored", corr_cnt, 192);
    for (int i = 0; i < FS; i++) begin tb_dat[i] = 4'b0010; tb_ref[i] = 4'b0001; end
    drive_frame(0, FS);
    check("qpsk_all_err", err_cnt, 192);

    // Four clean QPSK frames request QAM
    for (int f = 0; f < 4; f++) begin build_frame(0, 0); drive_frame(0, FS); end
    check("up_after_4", {high_req, low_req}, 2'b10);

    build_frame(1, 9);
    drive_frame(1, FS);
    check("qam_9err_low", {high_req, low_req}, 2'b01);

    // One error in frame 3 delays the upgrade to frame 7
    for (int f = 1; f <= 7; f++) begin
      build_frame(0, (f == 3) ? 1 : 0);
      drive_frame(0, FS);
      if (f == 6) check("no_up_at_6", high_req, 0);
    end
    check("up_at_7", {high_req, low_req}, 2'b10);

    build_frame(1, 8);
    drive_frame(1, FS);
    check("qam_8err_hold", {high_req, low_req}, 2'b10);
    build_frame(1, 9);
    drive_frame(1, FS);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      q = 1'($urandom);
      r = $urandom_range(0, 3);
      build_frame(q, (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 12) : -1);
      drive_frame(q, FS);
    end

    // Abort after 50 beats, then a full frame must start from zero
    build_frame(1, -1);
    drive_frame(1, 50);
    build_frame(0, 3);
    drive_frame(0, FS);

    // Reset in the middle of a frame
    build_frame(1, -1);
    qam = 1; qpsk = 0; cyc = 1; stb = 0; we = 1;
    tick;
    for (int i = 0; i < 30; i++) begin stb = 1; dat = tb_dat[i]; refs = tb_ref[i]; tick; end
    rst_n = 0; pulses = 0;
    repeat (2) begin tick; pulses += int'(frm_done) + int'(frm_abort); end
    check("rst_mid_pulses", pulses, 0);
    check("rst_mid_ack", ack, 0);
    check("rst_mid_err", err_cnt, 0);
    check("rst_mid_corr", corr_cnt, 0);
    check("rst_mid_frm_cnt", frm_cnt, 0);
    check("rst_mid_req", {high_req, low_req}, 2'b01);
    rst_n = 1; cyc = 0; stb = 0;
    model_reset();
    tick;
    build_frame(1, 5);
    drive_frame(1, FS);
    check("post_rst_frm_cnt", frm_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
